axo_regfile_sb: RTL and testbench

Parametrised integer register file for pipelined Axolotl cores. It provides NREAD combinational read ports, one write port with an optional same-cycle write-to-read bypass, and a per-register scoreboard of outstanding writes with a reserve handshake and a flush. It sits between decode/issue (reads, reservations) and writeback (writes), and supports both RV32I (NREG=32) and RV32E (NREG=16).

---
 rtl/axo_regfile_sb.sv | 84 ++++++++
 tb/tb_axo_regfile_sb.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/axo_regfile_sb.sv
// axo_regfile_sb: register file with write bypass and per-register write scoreboard
//   clk, rst            clock; asynchronous active-high reset
//   rs_idx/rs_data      NREAD combinational read ports (5-bit index, XLEN data)
//   rs_busy             per port: register awaits an outstanding write not satisfied this cycle
//   we/rd/din           write port
//   res_valid/res_rd    reservation request; res_ready acknowledges it
//   flush               clear all reservations at the next edge
//   pending             number of reserved registers
module axo_regfile_sb #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int NREAD  = 2,
    parameter int BYPASS = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [5*NREAD-1:0]    rs_idx,
    output logic [XLEN*NREAD-1:0] rs_data,
    output logic [NREAD-1:0]      rs_busy,
    input  logic                  we,
    input  logic [4:0]            rd,
    input  logic [XLEN-1:0]       din,
    input  logic                  res_valid,
    input  logic [4:0]            res_rd,
    output logic                  res_ready,
    input  logic                  flush,
    output logic [5:0]            pending
);
    localparam int AW = (NREG == 16) ? 4 : 5;

    // Index 0 and indices beyond NREG read as a constant zero and are never busy.
    function automatic logic vld(input logic [4:0] x);
        return (x != 5'd0) && (int'(x) < NREG);
    endfunction

    logic [XLEN-1:0] data [NREG];
    logic [NREG-1:0] busy, busy_nx;
    logic            rd_v, res_v, wr, acc, dec;
    logic [AW-1:0]   rd_a, res_a;

    assign rd_v  = vld(rd);
    assign res_v = vld(res_rd);
    assign rd_a  = rd[AW-1:0];
    assign res_a = res_rd[AW-1:0];
    assign wr    = we && rd_v;

    // A write landing on the same register this cycle frees it for the new producer.
    assign res_ready = !res_v || !busy[res_a] || (we && rd == res_rd);
    assign acc       = res_valid && res_ready && res_v;
    // Same-register write+reserve on a busy register nets to zero change: -1 here, +1 from acc.
    assign dec       = wr && busy[rd_a];

    // Reservation is applied after the write clear so the new producer wins.
    always_comb begin
        busy_nx = busy;
        if (wr) busy_nx[rd_a] = 1'b0;
        if (acc) busy_nx[res_a] = 1'b1;
        if (flush) busy_nx = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NREG; k++) data[k] <= '0;
            busy    <= '0;
            pending <= '0;
        end else begin
            if (wr) data[rd_a] <= din;
            busy    <= busy_nx;
            pending <= flush ? 6'd0 : pending + 6'(acc) - 6'(dec);
        end
    end

    for (genvar i = 0; i < NREAD; i++) begin : g_rd
        logic [4:0]    idx;
        logic [AW-1:0] a;
        logic          v, byp;
        assign idx = rs_idx[5*i +: 5];
        assign a   = idx[AW-1:0];
        assign v   = vld(idx);
        assign byp = (BYPASS != 0) && wr && (rd == idx);
        assign rs_data[XLEN*i +: XLEN] = !v ? '0 : byp ? din : data[a];
        assign rs_busy[i] = v && !byp && busy[a];
    end
endmodule

// File: tb/tb_axo_regfile_sb.sv
// tb_axo_regfile_sb: directed self-checking bench for axo_regfile_sb
//   dut_a: NREG=32, NREAD=2, BYPASS=1; dut_b: NREG=16, NREAD=1, BYPASS=0
module tb_axo_regfile_sb;
    logic        clk = 1'b0, rst = 1'b1;
    logic [9:0]  rs_idx = '0;
    logic [63:0] rs_data;
    logic [1:0]  rs_busy;
    logic        we = 0, res_valid = 0, flush = 0, res_ready;
    logic [4:0]  rd = '0, res_rd = '0;
    logic [31:0] din = '0;
    logic [5:0]  pending;

    logic [4:0]  b_idx = '0, b_rd = '0, b_res_rd = '0;
    logic [31:0] b_data, b_din = '0;
    logic        b_busy, b_we = 0, b_res_valid = 0, b_res_ready;
    logic [5:0]  b_pending;

    int n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    axo_regfile_sb dut_a (
        .clk(clk), .rst(rst), .rs_idx(rs_idx), .rs_data(rs_data), .rs_busy(rs_busy),
        .we(we), .rd(rd), .din(din), .res_valid(res_valid), .res_rd(res_rd),
        .res_ready(res_ready), .flush(flush), .pending(pending)
    );

    axo_regfile_sb #(.XLEN(32), .NREG(16), .NREAD(1), .BYPASS(0)) dut_b (
        .clk(clk), .rst(rst), .rs_idx(b_idx), .rs_data(b_data), .rs_busy(b_busy),
        .we(b_we), .rd(b_rd), .din(b_din), .res_valid(b_res_valid), .res_rd(b_res_rd),
        .res_ready(b_res_ready), .flush(1'b0), .pending(b_pending)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2;
        for (int i = 0; i < 32; i++) begin
            rs_idx = {5'(i), 5'(i)};
            #1;
            chk($sformatf("rst_d0_x%0d", i), rs_data[31:0], 32'h0);
            chk($sformatf("rst_d1_x%0d", i), rs_data[63:32], 32'h0);
            chk($sformatf("rst_busy_x%0d", i), 32'(rs_busy), 32'h0);
        end
        chk("rst_pending", 32'(pending), 32'h0);
        chk("rst_ready", 32'(res_ready), 32'h1);
        rst = 1'b0;
        tick;

        // write x5 with same-cycle read: bypass on A, old value on B
        we = 1; rd = 5; din = 32'hDEADBEEF; rs_idx = {5'd0, 5'd5};
        b_we = 1; b_rd = 5; b_din = 32'hDEADBEEF; b_idx = 5;
        #1;
        chk("byp_a", rs_data[31:0], 32'hDEADBEEF);
        chk("byp_a_p1_x0", rs_data[63:32], 32'h0);
        chk("nobyp_b_old", b_data, 32'h0);
        tick;
        we = 0; b_we = 0;
        #1;
        chk("wr_a_next", rs_data[31:0], 32'hDEADBEEF);
        chk("wr_b_next", b_data, 32'hDEADBEEF);

        // reserve x7
        res_valid = 1; res_rd = 7; rs_idx = {5'd5, 5'd7};
        #1;
        chk("res7_ready0", 32'(res_ready), 32'h1);
        tick;
        chk("res7_busy", 32'(rs_busy[0]), 32'h1);
        chk("res7_p1_notbusy", 32'(rs_busy[1]), 32'h0);
        chk("res7_pending", 32'(pending), 32'h1);
        chk("res7_ready_busy", 32'(res_ready), 32'h0);
        we = 1; rd = 7; din = 32'h12;
        #1;
        chk("res7_ready_wr", 32'(res_ready), 32'h1);
        chk("res7_busy_satisfied", 32'(rs_busy[0]), 32'h0);
        chk("res7_byp", rs_data[31:0], 32'h12);
        tick;
        we = 0; res_valid = 0;
        #1;
        chk("res7_still_busy", 32'(rs_busy[0]), 32'h1);
        chk("res7_pending_same", 32'(pending), 32'h1);
        chk("res7_data", rs_data[31:0], 32'h12);

        // reserve x3, x4, x9 then flush with x10 reservation
        res_valid = 1; res_rd = 3; tick;
        res_rd = 4; tick;
        res_rd = 9; tick;
        res_valid = 0;
        #1;
        chk("res_pending4", 32'(pending), 32'h4);
        rs_idx = {5'd9, 5'd3};
        #1;
        chk("res_x3_busy", 32'(rs_busy[0]), 32'h1);
        chk("res_x9_busy", 32'(rs_busy[1]), 32'h1);
        flush = 1; res_valid = 1; res_rd = 10;
        tick;
        flush = 0; res_valid = 0;
        #1;
        chk("flush_pending", 32'(pending), 32'h0);
        chk("flush_x3_x9", 32'(rs_busy), 32'h0);
        rs_idx = {5'd10, 5'd7};
        #1;
        chk("flush_x7_x10", 32'(rs_busy), 32'h0);
        rs_idx = {5'd9, 5'd4};
        #1;
        chk("flush_x4_x9", 32'(rs_busy), 32'h0);

        // NREG=16: x20 is a null index
        b_we = 1; b_rd = 20; b_din = 32'h55; b_res_valid = 1; b_res_rd = 20; b_idx = 20;
        #1;
        chk("b_x20_ready", 32'(b_res_ready), 32'h1);
        chk("b_x20_data_now", b_data, 32'h0);
        tick;
        b_we = 0; b_res_valid = 0;
        #1;
        chk("b_x20_data", b_data, 32'h0);
        chk("b_x20_busy", 32'(b_busy), 32'h0);
        chk("b_pending", 32'(b_pending), 32'h0);
        b_idx = 4;
        #1;
        chk("b_x4_alias", b_data, 32'h0);

        // x0 write ignored
        we = 1; rd = 0; din = 32'h1; rs_idx = {5'd5, 5'd0};
        #1;
        chk("x0_now", rs_data[31:0], 32'h0);
        tick;
        we = 0;
        #1;
        chk("x0_next", rs_data[31:0], 32'h0);
        chk("x5_kept", rs_data[63:32], 32'hDEADBEEF);

        // async reset with pending=3 and x2=0x99
        we = 1; rd = 2; din = 32'h99; res_valid = 1; res_rd = 1; tick;
        we = 0; res_rd = 2; tick;
        res_rd = 3; tick;
        res_valid = 0; rs_idx = {5'd2, 5'd2};
        #1;
        chk("pre_rst_pending", 32'(pending), 32'h3);
        chk("pre_rst_x2", rs_data[31:0], 32'h99);
        chk("pre_rst_busy", 32'(rs_busy), 32'h3);
        chk("pre_rst_ready", 32'(res_ready), 32'h0);
        #1;
        rst = 1;
        #1;
        chk("async_pending", 32'(pending), 32'h0);
        chk("async_x2", rs_data[31:0], 32'h0);
        chk("async_busy", 32'(rs_busy), 32'h0);
        chk("async_ready", 32'(res_ready), 32'h1);
        tick;
        rst = 0;
        tick;
        chk("post_rst_x2", rs_data[63:32], 32'h0);
        chk("post_rst_pending", 32'(pending), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
